// File: rtl/conv1x1_layer_sched.sv
// rtl/conv1x1_layer_sched.sv - layer-level scheduler for the 1x1 convolution read path
//
// Runs one 1x1 read pass per output-channel group: load weights, pulse the
// read controller, wait for its finish, drain the MAC/write-back pipeline,
// then report layer completion after the last group.
//
// Ports:
//   sclk                 in   system clock, rising edge
//   s_rst                in   asynchronous active-high reset
//   layer_start          in   start pulse, honoured only in IDLE
//   cfg_col_select       in   feature width select, latched at start
//   cfg_feature_row      in   last row index, latched at start
//   cfg_out_groups       in   number of output-channel groups, latched at start
//   feature_col_select   out  latched column select for the read controller
//   feature_row          out  latched last-row index for the read controller
//   weight_load_req      out  level, high for the whole weight-load phase
//   weight_group_idx     out  index of the group being processed
//   weight_load_done     in   pulse from the weight loader
//   conv1x1_start        out  one-cycle start pulse to the read controller
//   conv1x1_read_finish  in   pulse from the read controller
//   busy                 out  high whenever not idle
//   layer_done           out  one-cycle completion pulse

module conv1x1_layer_sched #(
  parameter int DRAIN_CYCLES = 8,
  parameter int GRP_W        = 8
) (
  input  logic             sclk,
  input  logic             s_rst,
  input  logic             layer_start,
  input  logic [2:0]       cfg_col_select,
  input  logic [6:0]       cfg_feature_row,
  input  logic [GRP_W-1:0] cfg_out_groups,
  output logic [2:0]       feature_col_select,
  output logic [6:0]       feature_row,
  output logic             weight_load_req,
  output logic [GRP_W-1:0] weight_group_idx,
  input  logic             weight_load_done,
  output logic             conv1x1_start,
  input  logic             conv1x1_read_finish,
  output logic             busy,
  output logic             layer_done
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_W  = 3'd1,
    START   = 3'd2,
    WAIT_RD = 3'd3,
    DRAIN   = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam logic [7:0] DRAIN_LOAD = 8'(DRAIN_CYCLES - 1);

  state_t           state;
  state_t           state_next;
  logic [GRP_W-1:0] group_cnt;
  logic [GRP_W-1:0] groups_q;
  logic [7:0]       drain_cnt;
  logic             last_group;
  logic             drain_end;

  assign last_group = (group_cnt == groups_q - GRP_W'(1));
  assign drain_end  = (drain_cnt == 8'd0);

  // State register
  always_ff @(posedge sclk or posedge s_rst) begin
    if (s_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (layer_start) begin
          state_next = (cfg_out_groups == '0) ? DONE : LOAD_W;
        end
      end
      LOAD_W: begin
        if (weight_load_done) begin
          state_next = START;
        end
      end
      START: begin
        state_next = WAIT_RD;
      end
      WAIT_RD: begin
        if (conv1x1_read_finish) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_end) begin
          state_next = last_group ? DONE : LOAD_W;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Moore outputs decoded from the registered state
  always_comb begin
    weight_load_req = 1'b0;
    conv1x1_start   = 1'b0;
    busy            = 1'b1;
    layer_done      = 1'b0;
    case (state)
      IDLE:    busy            = 1'b0;
      LOAD_W:  weight_load_req = 1'b1;
      START:   conv1x1_start   = 1'b1;
      DONE:    layer_done      = 1'b1;
      default: ;
    endcase
  end

  assign weight_group_idx = group_cnt;

  // Config latch, group counter and drain counter
  always_ff @(posedge sclk or posedge s_rst) begin
    if (s_rst) begin
      feature_col_select <= '0;
      feature_row        <= '0;
      groups_q           <= '0;
      group_cnt          <= '0;
      drain_cnt          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (layer_start) begin
            feature_col_select <= cfg_col_select;
            feature_row        <= cfg_feature_row;
            groups_q           <= cfg_out_groups;
            if (cfg_out_groups != '0) begin
              group_cnt <= '0;
            end
          end
        end
        WAIT_RD: begin
          if (conv1x1_read_finish) begin
            drain_cnt <= DRAIN_LOAD;
          end
        end
        DRAIN: begin
          if (drain_end) begin
            // The last group leaves for DONE, so the index never wraps.
            if (!last_group) begin
              group_cnt <= group_cnt + GRP_W'(1);
            end
          end else begin
            drain_cnt <= drain_cnt - 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv1x1_layer_sched.sv
// tb/tb_conv1x1_layer_sched.sv - directed self-checking bench for conv1x1_layer_sched

module tb_conv1x1_layer_sched;

  localparam int GRP_W = 8;

  logic             sclk = 1'b0;
  logic             s_rst = 1'b0;
  logic             layer_start = 1'b0;
  logic [2:0]       cfg_col_select = '0;
  logic [6:0]       cfg_feature_row = '0;
  logic [GRP_W-1:0] cfg_out_groups = '0;
  logic [2:0]       feature_col_select;
  logic [6:0]       feature_row;
  logic             weight_load_req;
  logic [GRP_W-1:0] weight_group_idx;
  logic             weight_load_done = 1'b0;
  logic             conv1x1_start;
  logic             conv1x1_read_finish = 1'b0;
  logic             busy;
  logic             layer_done;

  int checks = 0;
  int failures = 0;

  conv1x1_layer_sched #(
    .DRAIN_CYCLES(8),
    .GRP_W(GRP_W)
  ) dut (
    .sclk(sclk),
    .s_rst(s_rst),
    .layer_start(layer_start),
    .cfg_col_select(cfg_col_select),
    .cfg_feature_row(cfg_feature_row),
    .cfg_out_groups(cfg_out_groups),
    .feature_col_select(feature_col_select),
    .feature_row(feature_row),
    .weight_load_req(weight_load_req),
    .weight_group_idx(weight_group_idx),
    .weight_load_done(weight_load_done),
    .conv1x1_start(conv1x1_start),
    .conv1x1_read_finish(conv1x1_read_finish),
    .busy(busy),
    .layer_done(layer_done)
  );

  always #5 sclk = ~sclk;

  task automatic tick;
    @(posedge sclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_req"}, 32'(weight_load_req), 32'd0);
    chk({tag, "_cstart"}, 32'(conv1x1_start), 32'd0);
    chk({tag, "_done"}, 32'(layer_done), 32'd0);
    chk({tag, "_idx"}, 32'(weight_group_idx), 32'd0);
    chk({tag, "_col"}, 32'(feature_col_select), 32'd0);
    chk({tag, "_row"}, 32'(feature_row), 32'd0);
  endtask

  // Two groups; with spur set, stray inputs are injected without changing the timeline.
  task automatic run_two(input bit spur);
    for (int c = 0; c <= 40; c++) begin
      layer_start         = (c == 0) || (spur && (c == 12 || c == 33));
      cfg_col_select      = (c == 0) ? 3'd4 : 3'd5;
      cfg_feature_row     = (c == 0) ? 7'd25 : 7'd12;
      cfg_out_groups      = (c == 0) ? 8'd2 : 8'd0;
      weight_load_done    = (c == 3) || (c == 22) || (spur && (c == 6 || c == 15 || c == 30));
      conv1x1_read_finish = (c == 10) || (c == 29) || (spur && (c == 1 || c == 2 || c == 20 || c == 35));
      chk($sformatf("two%0d_cstart_c%0d", spur, c), 32'(conv1x1_start), 32'(c == 4 || c == 23));
      chk($sformatf("two%0d_req_c%0d", spur, c), 32'(weight_load_req),
          32'((c >= 1 && c <= 3) || (c >= 19 && c <= 22)));
      if ((c >= 1 && c <= 3) || (c >= 19 && c <= 22)) begin
        chk($sformatf("two%0d_idx_c%0d", spur, c), 32'(weight_group_idx), 32'(c >= 19));
      end
      chk($sformatf("two%0d_busy_c%0d", spur, c), 32'(busy), 32'(c >= 1 && c <= 38));
      chk($sformatf("two%0d_done_c%0d", spur, c), 32'(layer_done), 32'(c == 38));
      if (c >= 1) begin
        chk($sformatf("two%0d_col_c%0d", spur, c), 32'(feature_col_select), 32'd4);
        chk($sformatf("two%0d_row_c%0d", spur, c), 32'(feature_row), 32'd25);
      end
      tick();
    end
    layer_start         = 1'b0;
    weight_load_done    = 1'b0;
    conv1x1_read_finish = 1'b0;
  endtask

  int pulses;

  initial begin
    // Power-up reset
    #1 s_rst = 1'b1;
    #2;
    chk_all_zero("rst_async");
    tick();
    tick();
    s_rst = 1'b0;
    chk_all_zero("rst_idle");

    run_two(1'b0);
    run_two(1'b1);

    // Zero-group layer
    for (int c = 0; c <= 3; c++) begin
      layer_start     = (c == 0);
      cfg_col_select  = 3'd1;
      cfg_feature_row = 7'd3;
      cfg_out_groups  = 8'd0;
      chk($sformatf("zero_req_c%0d", c), 32'(weight_load_req), 32'd0);
      chk($sformatf("zero_cstart_c%0d", c), 32'(conv1x1_start), 32'd0);
      chk($sformatf("zero_done_c%0d", c), 32'(layer_done), 32'(c == 1));
      chk($sformatf("zero_busy_c%0d", c), 32'(busy), 32'(c == 1));
      if (c >= 1) begin
        chk($sformatf("zero_col_c%0d", c), 32'(feature_col_select), 32'd1);
      end
      tick();
    end
    layer_start = 1'b0;

    // Done and finish held high: minimum per-group cost of 11 cycles
    pulses = 0;
    for (int c = 0; c <= 25; c++) begin
      layer_start         = (c == 0);
      cfg_col_select      = 3'd4;
      cfg_feature_row     = 7'd25;
      cfg_out_groups      = 8'd2;
      weight_load_done    = 1'b1;
      conv1x1_read_finish = 1'b1;
      if (conv1x1_start === 1'b1) pulses++;
      chk($sformatf("same_cstart_c%0d", c), 32'(conv1x1_start), 32'(c == 2 || c == 13));
      chk($sformatf("same_done_c%0d", c), 32'(layer_done), 32'(c == 23));
      chk($sformatf("same_busy_c%0d", c), 32'(busy), 32'(c >= 1 && c <= 23));
      tick();
    end
    chk("same_pulse_count", 32'(pulses), 32'd2);
    layer_start         = 1'b0;
    weight_load_done    = 1'b0;
    conv1x1_read_finish = 1'b0;

    // Reset during WAIT_RD of group 1 of 3
    for (int c = 0; c <= 15; c++) begin
      layer_start         = (c == 0);
      cfg_col_select      = 3'd2;
      cfg_feature_row     = 7'd7;
      cfg_out_groups      = 8'd3;
      weight_load_done    = 1'b1;
      conv1x1_read_finish = (c == 3);
      if (c == 12) chk("rst3_idx1", 32'(weight_group_idx), 32'd1);
      if (c == 13) chk("rst3_cstart", 32'(conv1x1_start), 32'd1);
      if (c >= 14) chk($sformatf("rst3_wait_busy_c%0d", c), 32'(busy), 32'd1);
      tick();
    end
    layer_start = 1'b0;
    #2 s_rst = 1'b1;
    #1;
    chk_all_zero("rst_mid_async");
    tick();
    tick();
    s_rst = 1'b0;
    weight_load_done = 1'b0;
    for (int c = 0; c < 20; c++) begin
      chk($sformatf("rst_after_done_c%0d", c), 32'(layer_done), 32'd0);
      chk($sformatf("rst_after_busy_c%0d", c), 32'(busy), 32'd0);
      tick();
    end

    // Fresh single-group layer, then back-to-back start right after layer_done
    for (int c = 0; c <= 15; c++) begin
      layer_start         = (c == 0) || (c == 13);
      cfg_col_select      = (c < 13) ? 3'd3 : 3'd5;
      cfg_feature_row     = (c < 13) ? 7'd9 : 7'd12;
      cfg_out_groups      = 8'd1;
      weight_load_done    = 1'b1;
      conv1x1_read_finish = (c == 3);
      chk($sformatf("b2b_req_c%0d", c), 32'(weight_load_req), 32'(c == 1 || c == 14));
      if (c == 1 || c == 14) begin
        chk($sformatf("b2b_idx_c%0d", c), 32'(weight_group_idx), 32'd0);
      end
      chk($sformatf("b2b_cstart_c%0d", c), 32'(conv1x1_start), 32'(c == 2 || c == 15));
      chk($sformatf("b2b_done_c%0d", c), 32'(layer_done), 32'(c == 12));
      chk($sformatf("b2b_busy_c%0d", c), 32'(busy), 32'((c >= 1 && c <= 12) || c >= 14));
      if (c >= 1 && c <= 13) begin
        chk($sformatf("b2b_col_c%0d", c), 32'(feature_col_select), 32'd3);
        chk($sformatf("b2b_row_c%0d", c), 32'(feature_row), 32'd9);
      end
      if (c >= 14) begin
        chk($sformatf("b2b_col_c%0d", c), 32'(feature_col_select), 32'd5);
        chk($sformatf("b2b_row_c%0d", c), 32'(feature_row), 32'd12);
      end
      tick();
    end
    layer_start         = 1'b0;
    weight_load_done    = 1'b0;
    conv1x1_read_finish = 1'b0;
    s_rst = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
